gb_interrupt_controller: RTL and testbench
==========================================

# gb_interrupt_controller

Memory-mapped responder for the GameBoy interrupt registers IF (0xFF0F) and IE (0xFFFF), and the interrupt-side counterpart of the CPU's dispatch controls. It collects peripheral requests into IF and answers CPU bus reads and writes. On the CPU's `clear_interrupt_flag` strobe it picks the highest-priority pending source, clears that source's IF bit, and latches the source's vector for the following `write_interrupt_vector` cycle. It sits beside the CPU core on the internal bus and drives the HALT-wake / pending indication.

## Interface
- No parameters.
- `clk`  in  1  system clock (one clock domain)
- `rst_n`  in  1  asynchronous, active-low reset
- `bus_addr`  in  16  CPU address bus
- `bus_wdata`  in  8  CPU write data
- `bus_we`  in  1  CPU write strobe (CPU driving data bus)
- `bus_re`  in  1  CPU read strobe (CPU receiving data bus)
- `bus_rdata`  out  8  read data, valid when `bus_hit`
- `bus_hit`  out  1  `bus_re` is high and `bus_addr` is IF or IE
- `irq_req`  in  5  peripheral requests: [0] VBlank, [1] STAT, [2] Timer, [3] Serial, [4] Joypad
- `clear_interrupt_flag`  in  1  CPU dispatch strobe: clear the highest-priority pending IF bit and latch its vector
- `vector_consume`  in  1  CPU `write_interrupt_vector` cycle; returns the FSM to IDLE
- `int_pending`  out  1  `|(IE[4:0] & IF[4:0])`, combinational
- `int_vector`  out  16  latched dispatch vector

## Operation
- Registers:
  - `IF[4:0]`: reads back with bits 7:5 forced to 1.
  - `IE[7:0]`: fully read/write; only bits 4:0 take part in priority.
- Reads are combinational:
  - 0xFF0F returns `{3'b111, IF}`.
  - 0xFFFF returns `IE`.
  - Any other address: `bus_hit` = 0 and `bus_rdata` = 0x00.
- Writes to 0xFF0F or 0xFFFF take effect at the next clock edge. Writes to any other address are ignored.
- Next-IF priority, highest first, per bit:
  1. `irq_req` set.
  2. `clear_interrupt_flag` clear of the selected bit.
  3. CPU bus write value.
  4. Hold.
- A request always wins over a same-cycle write or clear of the same bit.
- Priority: the lowest-index bit set in `IE & IF`. The vector is 0x0040 + 8·index.
- FSM states:
  - IDLE: `clear_interrupt_flag` → latch the vector (or 0x0000 if `IE & IF` is 0, the cancelled-dispatch case), clear the selected bit, go to ACK.
  - ACK: `vector_consume` → IDLE. Another `clear_interrupt_flag` in ACK re-evaluates and re-latches (back-to-back dispatch).
- In ACK, `int_vector` holds steady even if IE/IF change.

## Timing
- Reset values: IF = 0, IE = 0x00, FSM = IDLE, `int_vector` = 0x0000. `bus_rdata`, `bus_hit` and `int_pending` follow from these registers.
- Reset is asynchronous. A reset mid-dispatch (in ACK) returns to IDLE with `int_vector` = 0x0000.
- Priority selection uses the pre-edge register values in the cycle `clear_interrupt_flag` is high.
- `int_vector` is valid from the edge after `clear_interrupt_flag` is sampled (1-cycle latency).
- A request arriving in the same cycle as `clear_interrupt_flag` is not considered until the next evaluation.
- `int_pending` reflects a new request one cycle after `irq_req` is sampled.

## Configuration
- `GB_IRQ_EDGE_DETECT_EN` defined:
  - `irq_req` bits are levels; a rising edge (registered previous value, reset to 0) sets IF.
  - A level held high sets IF once.
- `GB_IRQ_EDGE_DETECT_EN` undefined:
  - `irq_req` bits are one-cycle pulses OR'd directly into IF.
  - A level held high re-sets IF every cycle.

## Structure
- Add to the shared CPU package:
  - `interrupt_source_t` enum (VBLANK=0 … JOYPAD=4).
  - Constants `IF_ADDR` = 16'hFF0F, `IE_ADDR` = 16'hFFFF, `INT_VECTOR_BASE` = 16'h0040.
  - `int_ctrl_state_t` enum {INT_IDLE, INT_ACK}.
- One sub-module, `gb_interrupt_priority_enc`, which is combinational:
  - Input: 5-bit masked pending.
  - Outputs: `valid`, a 3-bit index, and a one-hot clear mask.

## Test plan
- **Reset read-back:** assert `rst_n` low, release, read 0xFF0F → 0xE0; read 0xFFFF → 0x00.
- **Priority dispatch:**
  - Stimulus: IE = 0x1F; pulse `irq_req` = 5'b10100; strobe `clear_interrupt_flag`.
  - Response: `int_vector` = 0x0050; IF reads 0xF0.
  - Then strobe `vector_consume` → FSM returns to IDLE.
- **Cancelled dispatch:** IE = 0x00 with IF = 0x01, then `clear_interrupt_flag` → `int_vector` = 0x0000 and IF is unchanged (0xE1).
- **Simultaneous write and request:** a CPU write of 0x00 to 0xFF0F in the same cycle as `irq_req[2]` → IF reads 0xE4.
- **Edge detect:** with `GB_IRQ_EDGE_DETECT_EN` defined, hold `irq_req[0]` high, clear IF by a bus write → IF stays 0xE0. Without the macro → IF reads 0xE1.
- **Reset mid-ACK:** assert `rst_n` while in ACK with `int_vector` = 0x0048 → `int_vector` = 0x0000, IE = 0x00, state IDLE.

Source files
------------

// File: rtl/gb_interrupt_controller_pkg.sv
// Shared types and constants for the GameBoy interrupt controller.
// Optional build macro GB_IRQ_EDGE_DETECT_EN is consumed by gb_interrupt_controller.sv.
package gb_interrupt_controller_pkg;

    typedef enum logic [2:0] {
        VBLANK = 3'd0,
        STAT   = 3'd1,
        TIMER  = 3'd2,
        SERIAL = 3'd3,
        JOYPAD = 3'd4
    } interrupt_source_t;

    typedef enum logic {
        INT_IDLE = 1'b0,
        INT_ACK  = 1'b1
    } int_ctrl_state_t;

    localparam logic [15:0] IF_ADDR         = 16'hFF0F;
    localparam logic [15:0] IE_ADDR         = 16'hFFFF;
    localparam logic [15:0] INT_VECTOR_BASE = 16'h0040;
    localparam int          NUM_IRQ         = 5;

    // Each source owns an 8-byte slot above the vector base.
    function automatic logic [15:0] irq_vector(input interrupt_source_t src);
        return INT_VECTOR_BASE + {10'b0, src, 3'b000};
    endfunction

endpackage

// File: rtl/gb_interrupt_priority_enc.sv
// Combinational lowest-index-first priority encoder over the masked pending interrupts.
// Not affected by GB_IRQ_EDGE_DETECT_EN.
module gb_interrupt_priority_enc
    import gb_interrupt_controller_pkg::*;
(
    input  logic [NUM_IRQ-1:0] i_pending,
    output logic               o_valid,
    output interrupt_source_t  o_index,
    output logic [NUM_IRQ-1:0] o_clear_mask
);

    always_comb begin
        o_valid      = |i_pending;
        o_index      = VBLANK;
        o_clear_mask = '0;
        // Walk from highest index down so the lowest set bit wins.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (i_pending[i]) begin
                o_index         = interrupt_source_t'(i[2:0]);
                o_clear_mask    = '0;
                o_clear_mask[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gb_interrupt_controller.sv
// GameBoy IF/IE register block with dispatch vector latch and pending indication.
// Define GB_IRQ_EDGE_DETECT_EN to treat irq_req as levels and set IF on rising edges only.
module gb_interrupt_controller
    import gb_interrupt_controller_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_bus_addr,
    input  logic [7:0]  i_bus_wdata,
    input  logic        i_bus_we,
    input  logic        i_bus_re,
    output logic [7:0]  o_bus_rdata,
    output logic        o_bus_hit,
    input  logic [4:0]  i_irq_req,
    input  logic        i_clear_interrupt_flag,
    input  logic        i_vector_consume,
    output logic        o_int_pending,
    output logic [15:0] o_int_vector
);

    logic [NUM_IRQ-1:0] r_if;
    logic [7:0]         r_ie;
    logic [15:0]        r_int_vector;
    int_ctrl_state_t    r_state;
    int_ctrl_state_t    w_state_next;

    logic [NUM_IRQ-1:0] w_masked;
    logic               w_valid;
    interrupt_source_t  w_index;
    logic [NUM_IRQ-1:0] w_clear_mask;
    logic [NUM_IRQ-1:0] w_req_set;
    logic [NUM_IRQ-1:0] w_if_next;
    logic               w_if_sel;
    logic               w_ie_sel;
    logic               w_if_wr;
    logic               w_ie_wr;
    logic               w_latch_vector;
    logic [15:0]        w_vector_next;

    assign w_if_sel = (i_bus_addr == IF_ADDR);
    assign w_ie_sel = (i_bus_addr == IE_ADDR);
    assign w_if_wr  = i_bus_we && w_if_sel;
    assign w_ie_wr  = i_bus_we && w_ie_sel;

    assign o_bus_hit = i_bus_re && (w_if_sel || w_ie_sel);

    always_comb begin
        o_bus_rdata = 8'h00;
        if (o_bus_hit) begin
            o_bus_rdata = w_if_sel ? {3'b111, r_if} : r_ie;
        end
    end

    assign w_masked      = r_ie[NUM_IRQ-1:0] & r_if;
    assign o_int_pending = |w_masked;

    gb_interrupt_priority_enc u_prio (
        .i_pending    (w_masked),
        .o_valid      (w_valid),
        .o_index      (w_index),
        .o_clear_mask (w_clear_mask)
    );

`ifdef GB_IRQ_EDGE_DETECT_EN
    logic [NUM_IRQ-1:0] r_irq_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_irq_prev <= '0;
        end else begin
            r_irq_prev <= i_irq_req;
        end
    end

    assign w_req_set = i_irq_req & ~r_irq_prev;
`else
    assign w_req_set = i_irq_req;
`endif

    // Per-bit next IF: request beats dispatch clear, which beats the bus write.
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_if_bit
        assign w_if_next[gi] = w_req_set[gi]                                ? 1'b1 :
                               (i_clear_interrupt_flag && w_clear_mask[gi]) ? 1'b0 :
                               w_if_wr                                      ? i_bus_wdata[gi] :
                                                                              r_if[gi];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_if <= '0;
            r_ie <= 8'h00;
        end else begin
            r_if <= w_if_next;
            if (w_ie_wr) begin
                r_ie <= i_bus_wdata;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= INT_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            INT_IDLE: if (i_clear_interrupt_flag) w_state_next = INT_ACK;
            INT_ACK: begin
                if (i_clear_interrupt_flag) begin
                    w_state_next = INT_ACK;
                end else if (i_vector_consume) begin
                    w_state_next = INT_IDLE;
                end
            end
            default: w_state_next = INT_IDLE;
        endcase
    end

    // A clear in either state (re)latches; nothing else disturbs the vector.
    always_comb begin
        w_latch_vector = 1'b0;
        w_vector_next  = 16'h0000;
        case (r_state)
            INT_IDLE, INT_ACK: w_latch_vector = i_clear_interrupt_flag;
            default:           w_latch_vector = 1'b0;
        endcase
        if (w_valid) begin
            w_vector_next = irq_vector(w_index);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_int_vector <= 16'h0000;
        end else if (w_latch_vector) begin
            r_int_vector <= w_vector_next;
        end
    end

    assign o_int_vector = r_int_vector;

endmodule

// File: tb/tb_gb_interrupt_controller.sv
// Randomized self-checking bench for gb_interrupt_controller against a behavioural model.
// Honours GB_IRQ_EDGE_DETECT_EN the same way as the design.
module tb_gb_interrupt_controller;
    import gb_interrupt_controller_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic [7:0]  bus_rdata;
    logic        bus_hit;
    logic [4:0]  irq_req;
    logic        clear_interrupt_flag;
    logic        vector_consume;
    logic        int_pending;
    logic [15:0] int_vector;

    always #5 clk = ~clk;

    gb_interrupt_controller dut (
        .i_clk                  (clk),
        .i_rst_n                (rst_n),
        .i_bus_addr             (bus_addr),
        .i_bus_wdata            (bus_wdata),
        .i_bus_we               (bus_we),
        .i_bus_re               (bus_re),
        .o_bus_rdata            (bus_rdata),
        .o_bus_hit              (bus_hit),
        .i_irq_req              (irq_req),
        .i_clear_interrupt_flag (clear_interrupt_flag),
        .i_vector_consume       (vector_consume),
        .o_int_pending          (int_pending),
        .o_int_vector           (int_vector)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [4:0]  m_if;
    logic [7:0]  m_ie;
    logic [15:0] m_vec;
    bit          m_ack;
    logic [4:0]  m_prev;

    // Values observed during the most recent step
    logic [7:0]  last_rdata;
    logic [15:0] last_vec;
    logic [31:0] last_state;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_if   = '0;
        m_ie   = 8'h00;
        m_vec  = 16'h0000;
        m_ack  = 1'b0;
        m_prev = '0;
    endtask

    task automatic step(input logic [15:0] a, input logic [7:0] wd, input logic we, input logic re,
                        input logic [4:0] irq, input logic clr, input logic cons);
        logic [4:0]  p, low, set, new_if;
        logic        hit;
        logic [7:0]  rd;
        int          idx;
        @(negedge clk);
        bus_addr = a; bus_wdata = wd; bus_we = we; bus_re = re;
        irq_req = irq; clear_interrupt_flag = clr; vector_consume = cons;
        #1;
        hit = re && (a == 16'hFF0F || a == 16'hFFFF);
        rd  = !hit ? 8'h00 : (a == 16'hFF0F) ? {3'b111, m_if} : m_ie;
        last_rdata = bus_rdata;
        last_vec   = int_vector;
        last_state = 32'(dut.r_state);
        check_eq("hit",     32'(bus_hit),     32'(hit));
        check_eq("rdata",   32'(bus_rdata),   32'(rd));
        check_eq("pending", 32'(int_pending), 32'(|(m_ie[4:0] & m_if)));
        check_eq("vector",  32'(int_vector),  32'(m_vec));
        check_eq("state",   last_state,       32'(m_ack));
`ifdef GB_IRQ_EDGE_DETECT_EN
        set = irq & ~m_prev;
`else
        set = irq;
`endif
        m_prev = irq;
        p   = m_ie[4:0] & m_if;
        low = p & (~p + 5'd1);
        idx = $clog2(low);
        new_if = m_if;
        if (we && a == 16'hFF0F) new_if = wd[4:0];
        if (clr) begin
            new_if = new_if & ~low;
            m_vec  = (p != 0) ? 16'h0040 + 16'(8 * idx) : 16'h0000;
        end
        new_if = new_if | set;
        if (we && a == 16'hFFFF) m_ie = wd;
        m_if = new_if;
        if (clr) m_ack = 1'b1;
        else if (cons) m_ack = 1'b0;
        @(posedge clk);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d, input logic [4:0] irq);
        step(a, d, 1'b1, 1'b0, irq, 1'b0, 1'b0);
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a, input logic [4:0] irq, input logic [7:0] exp);
        step(a, 8'h00, 1'b0, 1'b1, irq, 1'b0, 1'b0);
        check_eq(tag, 32'(last_rdata), 32'(exp));
    endtask

    initial begin
        logic [15:0] a;
        logic [4:0]  irq;
        logic        clr, cons;

        rst_n = 1'b0;
        bus_addr = 16'h0000; bus_wdata = 8'h00; bus_we = 1'b0; bus_re = 1'b0;
        irq_req = '0; clear_interrupt_flag = 1'b0; vector_consume = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_eq("reset_vec", 32'(int_vector), 32'h0000);
        check_eq("reset_pending", 32'(int_pending), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        rd_chk("reset_if", 16'hFF0F, 5'b0, 8'hE0);
        rd_chk("reset_ie", 16'hFFFF, 5'b0, 8'h00);

        // Priority dispatch: timer beats joypad
        wr(16'hFFFF, 8'h1F, 5'b0);
        step(16'h0000, 8'h00, 1'b0, 1'b0, 5'b10100, 1'b0, 1'b0);
        step(16'h0000, 8'h00, 1'b0, 1'b0, 5'b00000, 1'b1, 1'b0);
        rd_chk("dispatch_if", 16'hFF0F, 5'b0, 8'hF0);
        check_eq("dispatch_vec", 32'(last_vec), 32'h0050);
        check_eq("dispatch_ack", last_state, 32'(INT_ACK));
        step(16'h0000, 8'h00, 1'b0, 1'b0, 5'b0, 1'b0, 1'b1);
        rd_chk("consume_if", 16'hFF0F, 5'b0, 8'hF0);
        check_eq("consume_idle", last_state, 32'(INT_IDLE));

        // Cancelled dispatch
        wr(16'hFFFF, 8'h00, 5'b0);
        wr(16'hFF0F, 8'h01, 5'b0);
        step(16'h0000, 8'h00, 1'b0, 1'b0, 5'b0, 1'b1, 1'b0);
        rd_chk("cancel_if", 16'hFF0F, 5'b0, 8'hE1);
        check_eq("cancel_vec", 32'(last_vec), 32'h0000);
        step(16'h0000, 8'h00, 1'b0, 1'b0, 5'b0, 1'b0, 1'b1);

        // Request wins over a same-cycle write
        wr(16'hFF0F, 8'h00, 5'b00100);
        rd_chk("wr_vs_req", 16'hFF0F, 5'b0, 8'hE4);

        // Held request across an IF clear
        step(16'h0000, 8'h00, 1'b0, 1'b0, 5'b00001, 1'b0, 1'b0);
        wr(16'hFF0F, 8'h00, 5'b00001);
`ifdef GB_IRQ_EDGE_DETECT_EN
        rd_chk("held_req", 16'hFF0F, 5'b00001, 8'hE0);
`else
        rd_chk("held_req", 16'hFF0F, 5'b00001, 8'hE1);
`endif
        wr(16'hFF0F, 8'h00, 5'b0);

        // Asynchronous reset while in ACK
        wr(16'hFFFF, 8'h1F, 5'b0);
        wr(16'hFF0F, 8'h02, 5'b0);
        step(16'h0000, 8'h00, 1'b0, 1'b0, 5'b0, 1'b1, 1'b0);
        rd_chk("ack_ie", 16'hFFFF, 5'b0, 8'h1F);
        check_eq("ack_vec", 32'(last_vec), 32'h0048);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_vec", 32'(int_vector), 32'h0000);
        check_eq("async_rst_state", 32'(dut.r_state), 32'(INT_IDLE));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        rd_chk("rst_ie", 16'hFFFF, 5'b0, 8'h00);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0:       a = 16'hFF0F;
                1:       a = 16'hFFFF;
                2:       a = 16'($urandom);
                default: a = 16'hFF00 | 16'($urandom_range(0, 255));
            endcase
            irq  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
            clr  = ($urandom_range(0, 5) == 0);
            cons = !clr && ($urandom_range(0, 4) == 0);
            step(a, 8'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), irq, clr, cons);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
